// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and external hold; optional STALL_COUNT_EN bubble counter.
// Latency: 1 cycle ID->EX. Backpressure: Hold freezes the register; Stall (combinational) freezes PC and IF/ID.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegDst,
    input  logic              ALUSrc,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              ALUOp1,
    input  logic              ALUOp0,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] SignExtImm,
    input  logic [DATA_W-1:0] PCPlus4,
    input  logic [REG_W-1:0]  Rs,
    input  logic [REG_W-1:0]  Rt,
    input  logic [REG_W-1:0]  Rd,
    input  logic              Flush,
    input  logic              Hold,
    output logic              Stall,
    output logic              RegDst_EX,
    output logic              ALUSrc_EX,
    output logic              MemtoReg_EX,
    output logic              RegWrite_EX,
    output logic              MemRead_EX,
    output logic              MemWrite_EX,
    output logic              Branch_EX,
    output logic              ALUOp1_EX,
    output logic              ALUOp0_EX,
    output logic [DATA_W-1:0] ReadData1_EX,
    output logic [DATA_W-1:0] ReadData2_EX,
    output logic [DATA_W-1:0] SignExtImm_EX,
    output logic [DATA_W-1:0] PCPlus4_EX,
    output logic [REG_W-1:0]  Rs_EX,
    output logic [REG_W-1:0]  Rt_EX,
    output logic [REG_W-1:0]  Rd_EX,
    output logic [15:0]       StallCount
);

    typedef struct packed {
        logic              reg_dst;
        logic              alu_src;
        logic              memto_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              alu_op1;
        logic              alu_op0;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } ex_bundle_t;

    ex_bundle_t in_bundle;
    ex_bundle_t ex_d;
    ex_bundle_t ex_q;
    logic       haz;

    assign in_bundle = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                        ALUOp1, ALUOp0, ReadData1, ReadData2, SignExtImm, PCPlus4, Rs, Rt, Rd};

    // $0 is never a real producer, so a load targeting it cannot cause a hazard.
    assign haz   = ex_q.mem_read & (ex_q.rt != '0) & ((ex_q.rt == Rs) | (ex_q.rt == Rt));
    assign Stall = haz & ~Flush & ~rst;

    always_comb begin
        ex_d = in_bundle;
        if (Flush) begin
            ex_d = '0;
        end else if (Hold) begin
            ex_d = ex_q;
        end else if (haz) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign RegDst_EX     = ex_q.reg_dst;
    assign ALUSrc_EX     = ex_q.alu_src;
    assign MemtoReg_EX   = ex_q.memto_reg;
    assign RegWrite_EX   = ex_q.reg_write;
    assign MemRead_EX    = ex_q.mem_read;
    assign MemWrite_EX   = ex_q.mem_write;
    assign Branch_EX     = ex_q.branch;
    assign ALUOp1_EX     = ex_q.alu_op1;
    assign ALUOp0_EX     = ex_q.alu_op0;
    assign ReadData1_EX  = ex_q.rd1;
    assign ReadData2_EX  = ex_q.rd2;
    assign SignExtImm_EX = ex_q.imm;
    assign PCPlus4_EX    = ex_q.pc4;
    assign Rs_EX         = ex_q.rs;
    assign Rt_EX         = ex_q.rt;
    assign Rd_EX         = ex_q.rd;

`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic        haz_bubble;

    // Only bubbles actually loaded because of the hazard count; Flush and Hold take priority.
    assign haz_bubble = haz & ~Flush & ~Hold;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (haz_bubble && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = '0;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute.
- Captures the decode_control signal bundle, register-file read data, sign-extended immediate, register specifiers and PC+4 each cycle.
- Contains the load-use hazard detector: on a hazard it stalls the PC and IF/ID register and inserts one bubble into EX.
- Also handles branch flush and an external pipeline freeze.

Parameters:
- DATA_W, 32, width of read data, immediate and PC+4.
- REG_W, 5, width of register specifiers.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0  input  1 each  decode control bundle.
- ReadData1, ReadData2  input  DATA_W  register-file outputs.
- SignExtImm  input  DATA_W  sign-extended immediate.
- PCPlus4  input  DATA_W  PC+4 of the ID instruction.
- Rs, Rt, Rd  input  REG_W  ID instruction specifiers.
- Flush  input  1  branch taken; squash the ID instruction.
- Hold  input  1  external freeze, e.g. memory wait.
- Stall  output  1  combinational; deasserts PC write and IF/ID load.
- RegDst_EX … ALUOp0_EX  output  1 each  registered control bundle.
- ReadData1_EX, ReadData2_EX, SignExtImm_EX, PCPlus4_EX  output  DATA_W  registered data.
- Rs_EX, Rt_EX, Rd_EX  output  REG_W  registered specifiers.
- StallCount  output  16  bubble counter (see Optional Feature).

Behaviour:
- Reset: all registered outputs are 0, so EX holds a bubble. Stall is 0 while rst=1.
- Hazard: Haz = MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Rs) | (Rt_EX == Rt)).
  - Stall = Haz & ~Flush & ~rst.
  - Rt_EX == 0 never raises a hazard.
- Per-edge priority:
  1. rst: clear all registers.
  2. Flush: load a bubble (every control and data field 0).
  3. Hold: keep all registers unchanged.
  4. Haz: load a bubble.
  5. Otherwise: load all inputs.
- Latency: inputs appear on the _EX outputs 1 cycle later.
- Bubble length is exactly 1 cycle. After the bubble MemRead_EX=0, so Stall falls the next cycle and the held ID instruction loads.
- Hold with Haz: register holds, Stall stays asserted, no bubble. The bubble is inserted on the first cycle Hold drops.
- Flush with Haz: Flush wins, bubble is inserted, Stall=0.
- Back-to-back load-use chains give one bubble per dependent pair.
- A load followed by a non-dependent instruction causes no stall.
- Store after load (MemWrite in ID) using Rt_EX as its data source still stalls, because the Rt comparison is unconditional.
- Reset mid-stall: the next cycle has all outputs 0 and Stall=0.

Optional Feature:
- Macro: STALL_COUNT_EN.
- Defined: StallCount is a 16-bit saturating counter.
  - Increments on each edge where a bubble is loaded due to Haz (not Flush).
  - Holds at 16'hFFFF.
  - Cleared by rst.
- Undefined: no counter logic; StallCount is tied to 0.

Test Plan:
- Reset: assert rst with nonzero inputs for 2 cycles -> all _EX outputs 0, Stall=0. Deassert rst -> inputs appear on _EX 1 cycle later.
- Load-use: lw $8 then add using Rs=8 -> Stall=1 for exactly 1 cycle, one all-zero bubble in EX, then the add appears with Rs_EX=8. StallCount increments by 1.
- $0 exemption: lw to Rt=0 then instruction with Rs=0 -> Stall stays 0, no bubble.
- Flush over hazard: Flush=1 in the same cycle as a load-use hazard -> Stall=0, bubble loaded, StallCount unchanged.
- Hold: Hold=1 for 3 cycles with changing inputs -> _EX outputs frozen. Hazard present under Hold -> Stall=1 throughout, bubble inserted only on the first cycle Hold=0.
- Saturation (STALL_COUNT_EN): force 65536 hazard bubbles -> StallCount=16'hFFFF and stays there.
